// File: rtl/cpu15_mem_pkg.sv
// Purpose: shared constants, port FSM state and address classification for the CPU15 data RAM.
// Latency: none (types and a pure combinational helper).
// Backpressure: n/a.
package cpu15_mem_pkg;

  localparam int unsigned RAM_WORDS = 8;
  localparam logic [7:0]  IO64_ADDR = 8'h40;
  localparam logic [7:0]  IO65_ADDR = 8'h41;  // input-only port, never a legal store target

  typedef enum logic {IDLE, PEND} io_state_t;

  typedef enum logic [1:0] {ACLS_RAM, ACLS_OUT, ACLS_ILLEGAL} addr_cls_t;

  // Classifies an 8-bit data address; the read decoder uses the same split.
  function automatic addr_cls_t addr_class(input logic [7:0]  ad,
                                           input int unsigned words,
                                           input logic [7:0]  out_addr);
    if (32'(ad) < words) begin
      return ACLS_RAM;
    end else if (ad == out_addr) begin
      return ACLS_OUT;
    end else begin
      return ACLS_ILLEGAL;
    end
  endfunction

endpackage

// File: rtl/io64_out_port.sv
// Purpose: output port 64 holding register with a valid/ack handshake to the external device.
// Latency: a store is visible on out_data/valid one edge after it is sampled.
// Backpressure: busy = valid & ~ack; a store arriving while busy is dropped and must be retried.
module io64_out_port
  import cpu15_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        store,
  input  logic [15:0] data,
  input  logic        ack,
  output logic [15:0] out_data,
  output logic        valid,
  output logic        busy
);

  io_state_t state;
  io_state_t state_nxt;
  logic      load;

  // State register; reset abandons any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and load enable: accept in IDLE, replace on ack in PEND, otherwise hold.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (store) begin
          load      = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (store && ack) begin
          load = 1'b1;
        end else if (!store && ack) begin
          state_nxt = IDLE;
        end
      end
      default: ;
    endcase
  end

  // Data register; keeps its value after the device takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= 16'h0000;
    end else if (load) begin
      out_data <= data;
    end
  end

  assign valid = (state == PEND);
  assign busy  = valid & ~ack;

endmodule

// File: rtl/ram_wr.sv
// Purpose: store-side decode for the CPU15 data RAM: eight RAM words, output port 64 and a sticky ERR.
// Latency: 1 cycle from a sampled store to RAM_n / IO64_OUT.
// Backpressure: BUSY high drops a port-64 store; RAM stores are always accepted.
module ram_wr #(
  parameter int unsigned RAM_WORDS = cpu15_mem_pkg::RAM_WORDS,
  parameter logic [7:0]  IO64_ADDR = cpu15_mem_pkg::IO64_ADDR
) (
  input  logic        CLK_WR,
  input  logic        RST_N,
  input  logic        WE,
  input  logic [7:0]  RAM_AD_IN,
  input  logic [15:0] RAM_IN,
  input  logic        IO64_ACK,
  output logic [15:0] RAM_0,
  output logic [15:0] RAM_1,
  output logic [15:0] RAM_2,
  output logic [15:0] RAM_3,
  output logic [15:0] RAM_4,
  output logic [15:0] RAM_5,
  output logic [15:0] RAM_6,
  output logic [15:0] RAM_7,
  output logic [15:0] IO64_OUT,
  output logic        IO64_VALID,
  output logic        BUSY,
  output logic        ERR
);

  import cpu15_mem_pkg::*;

  addr_cls_t   ad_cls;
  logic        ram_st;
  logic        port_st;
  logic        bad_st;
  logic [15:0] ram [RAM_WORDS];

  // Split the store request by address class.
  always_comb begin
    ad_cls  = addr_class(RAM_AD_IN, RAM_WORDS, IO64_ADDR);
    ram_st  = WE && (ad_cls == ACLS_RAM);
    port_st = WE && (ad_cls == ACLS_OUT);
    bad_st  = WE && (ad_cls == ACLS_ILLEGAL);
  end

  // RAM array: only the addressed word takes the store data.
  always_ff @(posedge CLK_WR or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < RAM_WORDS; i++) begin
        ram[i] <= 16'h0000;
      end
    end else if (ram_st) begin
      for (int i = 0; i < RAM_WORDS; i++) begin
        if (RAM_AD_IN == 8'(i)) begin
          ram[i] <= RAM_IN;
        end
      end
    end
  end

  // Sticky illegal-address flag, cleared only by reset.
  always_ff @(posedge CLK_WR or negedge RST_N) begin
    if (!RST_N) begin
      ERR <= 1'b0;
    end else if (bad_st) begin
      ERR <= 1'b1;
    end
  end

  assign RAM_0 = ram[0];
  assign RAM_1 = ram[1];
  assign RAM_2 = ram[2];
  assign RAM_3 = ram[3];
  assign RAM_4 = ram[4];
  assign RAM_5 = ram[5];
  assign RAM_6 = ram[6];
  assign RAM_7 = ram[7];

  io64_out_port u_io64 (
    .clk      (CLK_WR),
    .rst_n    (RST_N),
    .store    (port_st),
    .data     (RAM_IN),
    .ack      (IO64_ACK),
    .out_data (IO64_OUT),
    .valid    (IO64_VALID),
    .busy     (BUSY)
  );

endmodule

// File: tb/tb_ram_wr.sv
// Purpose: directed bench for ram_wr with a queue-based scoreboard of expected output state.
// Latency: expectations are pushed one edge after each stimulus vector and compared at the next falling edge.
// Backpressure: exercises BUSY drops, back-to-back port-64 transfers and ack streaming.
module tb_ram_wr;

  logic        CLK_WR;
  logic        RST_N;
  logic        WE;
  logic [7:0]  RAM_AD_IN;
  logic [15:0] RAM_IN;
  logic        IO64_ACK;
  logic [15:0] RAM_0, RAM_1, RAM_2, RAM_3, RAM_4, RAM_5, RAM_6, RAM_7;
  logic [15:0] IO64_OUT;
  logic        IO64_VALID;
  logic        BUSY;
  logic        ERR;

  typedef struct packed {
    logic [7:0][15:0] ram;
    logic [15:0]      out;
    logic             valid;
    logic             busy;
    logic             err;
  } exp_t;

  exp_t             sb[$];
  exp_t             exp;
  logic [7:0][15:0] act_ram;
  int               checks = 0;
  int               errors = 0;
  int               xfers  = 0;
  int               base;

  ram_wr dut (
    .CLK_WR     (CLK_WR),
    .RST_N      (RST_N),
    .WE         (WE),
    .RAM_AD_IN  (RAM_AD_IN),
    .RAM_IN     (RAM_IN),
    .IO64_ACK   (IO64_ACK),
    .RAM_0      (RAM_0),
    .RAM_1      (RAM_1),
    .RAM_2      (RAM_2),
    .RAM_3      (RAM_3),
    .RAM_4      (RAM_4),
    .RAM_5      (RAM_5),
    .RAM_6      (RAM_6),
    .RAM_7      (RAM_7),
    .IO64_OUT   (IO64_OUT),
    .IO64_VALID (IO64_VALID),
    .BUSY       (BUSY),
    .ERR        (ERR)
  );

  assign act_ram = {RAM_7, RAM_6, RAM_5, RAM_4, RAM_3, RAM_2, RAM_1, RAM_0};

  initial CLK_WR = 1'b0;
  always #5 CLK_WR = ~CLK_WR;

  // Completed handshakes: one per edge with valid and ack both high.
  always @(posedge CLK_WR) begin
    if (IO64_VALID && IO64_ACK) xfers <= xfers + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    for (int i = 0; i < 8; i++) chk($sformatf("%s ram_%0d", tag, i), 32'(act_ram[i]), 32'(e.ram[i]));
    chk({tag, " io64_out"}, 32'(IO64_OUT), 32'(e.out));
    chk({tag, " io64_valid"}, 32'(IO64_VALID), 32'(e.valid));
    chk({tag, " busy"}, 32'(BUSY), 32'(e.busy));
    chk({tag, " err"}, 32'(ERR), 32'(e.err));
  endtask

  // Monitor: compare the DUT against the oldest expectation each falling edge.
  always @(negedge CLK_WR) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk_all("sb", e);
    end
  end

  task automatic drive(input logic we, input logic [7:0] ad, input logic [15:0] d, input logic ack);
    WE        = we;
    RAM_AD_IN = ad;
    RAM_IN    = d;
    IO64_ACK  = ack;
  endtask

  // Apply one vector for one edge; exp must already describe the state after that edge.
  task automatic step(input logic we, input logic [7:0] ad, input logic [15:0] d, input logic ack);
    @(negedge CLK_WR);
    #1;
    drive(we, ad, d, ack);
    @(posedge CLK_WR);
    #1;
    sb.push_back(exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp = '0;
    RST_N = 1'b1;
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    #1 RST_N = 1'b0;
    #2 chk_all("reset", exp);
    @(negedge CLK_WR);
    #1 RST_N = 1'b1;

    // Single store to word 3.
    exp.ram[3] = 16'hA5A5;
    step(1'b1, 8'h03, 16'hA5A5, 1'b0);

    // Fill all words, then idle and hold.
    for (int a = 0; a < 8; a++) begin
      exp.ram[a] = 16'h1000 + 16'(a);
      step(1'b1, 8'(a), 16'h1000 + 16'(a), 1'b0);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 16'hFFFF, 1'b0);

    // Port 64: accept, drop while busy, then ack back to idle.
    exp.out = 16'h1234; exp.valid = 1'b1; exp.busy = 1'b1;
    step(1'b1, 8'h40, 16'h1234, 1'b0);
    step(1'b1, 8'h40, 16'h5678, 1'b0);
    exp.valid = 1'b0; exp.busy = 1'b0;
    step(1'b0, 8'h00, 16'h0000, 1'b1);

    // Back-to-back replacement with ack in PEND.
    exp.out = 16'h1111; exp.valid = 1'b1; exp.busy = 1'b1;
    step(1'b1, 8'h40, 16'h1111, 1'b0);
    exp.out = 16'hBEEF; exp.busy = 1'b0;
    step(1'b1, 8'h40, 16'hBEEF, 1'b1);

    // Streaming with ack held high: one transfer per cycle.
    base = xfers;
    for (int k = 0; k < 4; k++) begin
      exp.out = 16'hC000 + 16'(k);
      step(1'b1, 8'h40, 16'hC000 + 16'(k), 1'b1);
    end
    chk("stream_xfers", 32'(xfers - base), 32'd4);
    exp.valid = 1'b0;
    step(1'b0, 8'h00, 16'h0000, 1'b1);

    // Illegal addresses set the sticky ERR and change nothing else.
    exp.err = 1'b1;
    step(1'b1, 8'h41, 16'hDEAD, 1'b0);
    step(1'b1, 8'h08, 16'hDEAD, 1'b0);
    step(1'b1, 8'hFF, 16'hDEAD, 1'b0);
    exp.ram[2] = 16'h2222;
    step(1'b1, 8'h02, 16'h2222, 1'b0);

    // Asynchronous reset in the middle of a pending transfer.
    exp.ram[5] = 16'hFFFF;
    step(1'b1, 8'h05, 16'hFFFF, 1'b0);
    exp.out = 16'h7777; exp.valid = 1'b1; exp.busy = 1'b1;
    step(1'b1, 8'h40, 16'h7777, 1'b0);
    @(negedge CLK_WR);
    #1;
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    RST_N = 1'b0;
    #1;
    exp = '0;
    chk_all("midreset", exp);
    @(posedge CLK_WR);
    @(negedge CLK_WR);
    #1;
    RST_N = 1'b1;
    drive(1'b1, 8'h40, 16'hABCD, 1'b0);
    @(posedge CLK_WR);
    #1;
    exp.out = 16'hABCD; exp.valid = 1'b1; exp.busy = 1'b1;
    sb.push_back(exp);
    exp.valid = 1'b0; exp.busy = 1'b0;
    step(1'b0, 8'h00, 16'h0000, 1'b1);

    repeat (2) @(negedge CLK_WR);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
